pixel_filter: RTL and testbench

PIXEL_FILTER -- requirements
Module: pixel_filter

---
 rtl/pixel_filter_pkg.sv | 16 +
 rtl/pixel_filter_if.sv | 14 +
 rtl/axis_pipe_stage.sv | 29 ++
 rtl/pixel_filter.sv | 138 +++++++++++++
 tb/tb_pixel_filter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_filter_pkg.sv
// Shared types and constants for the pixel filter: filter modes and BT.601-style luma weights.
package pixel_filter_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        GREY   = 2'd1,
        INVERT = 2'd2,
        THRESH = 2'd3
    } mode_e;

    localparam int unsigned COEF_R     = 77;
    localparam int unsigned COEF_G     = 150;
    localparam int unsigned COEF_B     = 29;
    localparam int unsigned GRAY_SHIFT = 8;

endpackage

// File: rtl/pixel_filter_if.sv
// AXI4-Stream video bus carrying one {R,B,G} pixel per beat with start-of-frame and end-of-line flags.
interface pixel_filter_if #(
    parameter int unsigned CH_W = 8
);
    logic [3*CH_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);

endinterface

// File: rtl/axis_pipe_stage.sv
// One elastic register slice: loads when empty or when downstream takes the held beat.
module axis_pipe_stage #(
    parameter int unsigned W = 8
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         in_valid,
    output logic         in_ready_c,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready_c = !out_valid || out_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready_c) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/pixel_filter.sv
// Two-stage streaming pixel filter (bypass / greyscale / invert / threshold) with a completed-frame counter.
module pixel_filter
    import pixel_filter_pkg::*;
#(
    parameter int unsigned CH_W   = 8,
    parameter int unsigned FCNT_W = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    pixel_filter_if.slave     s_axis_video,
    pixel_filter_if.master    m_axis_video,
    input  logic [1:0]        mode,
    input  logic [CH_W-1:0]   threshold,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int unsigned PIX_W  = 3 * CH_W;
    localparam int unsigned PROD_W = CH_W + 10;
    localparam int unsigned S1_W   = 2 + CH_W + 3 * PROD_W + PIX_W + 2;
    localparam int unsigned S2_W   = PIX_W + 2;

    mode_e             active_mode;
    logic [CH_W-1:0]   active_thr;
    mode_e             beat_mode;
    logic [CH_W-1:0]   beat_thr;
    logic              in_hs;
    logic              out_hs;
    logic              seen_sof;

    logic [CH_W-1:0]   in_r, in_g, in_b;
    logic [PROD_W-1:0] prod_r, prod_g, prod_b;

    logic [S1_W-1:0]   s1_in, s1_out;
    logic              s1_valid, s1_ready_c;
    logic [1:0]        s1_mode_bits;
    logic [CH_W-1:0]   s1_thr;
    logic [PROD_W-1:0] s1_pr, s1_pg, s1_pb;
    logic [PIX_W-1:0]  s1_pix;
    logic              s1_user, s1_last;

    logic [PROD_W-1:0] gray_sum;
    logic [CH_W-1:0]   gray;
    logic [PIX_W-1:0]  pix_out;

    logic [S2_W-1:0]   s2_in, s2_out;
    logic              s2_valid, s2_ready_c;

    assign in_hs  = s_axis_video.tvalid && s_axis_video.tready;
    assign out_hs = m_axis_video.tvalid && m_axis_video.tready;
    assign s_axis_video.tready = aresetn && s1_ready_c;

    // A start-of-frame beat uses the freshly presented controls, so the new mode covers it too
    always_comb begin
        beat_mode = active_mode;
        beat_thr  = active_thr;
        if (s_axis_video.tuser) begin
            beat_mode = mode_e'(mode);
            beat_thr  = threshold;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            active_mode <= BYPASS;
            active_thr  <= '0;
        end else if (in_hs && s_axis_video.tuser) begin
            active_mode <= mode_e'(mode);
            active_thr  <= threshold;
        end
    end

    assign in_r   = s_axis_video.tdata[3*CH_W-1 -: CH_W];
    assign in_b   = s_axis_video.tdata[2*CH_W-1 -: CH_W];
    assign in_g   = s_axis_video.tdata[CH_W-1:0];
    assign prod_r = PROD_W'(in_r) * PROD_W'(COEF_R);
    assign prod_g = PROD_W'(in_g) * PROD_W'(COEF_G);
    assign prod_b = PROD_W'(in_b) * PROD_W'(COEF_B);

    assign s1_in = {beat_mode, beat_thr, prod_r, prod_g, prod_b,
                    s_axis_video.tdata, s_axis_video.tuser, s_axis_video.tlast};

    axis_pipe_stage #(.W(S1_W)) u_stage1 (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_valid   (s_axis_video.tvalid),
        .in_ready_c (s1_ready_c),
        .in_data    (s1_in),
        .out_valid  (s1_valid),
        .out_ready  (s2_ready_c),
        .out_data   (s1_out)
    );

    assign {s1_mode_bits, s1_thr, s1_pr, s1_pg, s1_pb, s1_pix, s1_user, s1_last} = s1_out;

    // Weights sum to 256, so the shifted luma always fits in CH_W bits
    always_comb begin
        gray_sum = s1_pr + s1_pg + s1_pb;
        gray     = CH_W'(gray_sum >> GRAY_SHIFT);
        pix_out  = s1_pix;
        case (mode_e'(s1_mode_bits))
            BYPASS:  pix_out = s1_pix;
            GREY:    pix_out = {3{gray}};
            INVERT:  pix_out = ~s1_pix;
            THRESH:  pix_out = (gray >= s1_thr) ? {PIX_W{1'b1}} : '0;
            default: pix_out = s1_pix;
        endcase
    end

    assign s2_in = {s1_user, s1_last, pix_out};

    axis_pipe_stage #(.W(S2_W)) u_stage2 (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_valid   (s1_valid),
        .in_ready_c (s2_ready_c),
        .in_data    (s2_in),
        .out_valid  (s2_valid),
        .out_ready  (m_axis_video.tready),
        .out_data   (s2_out)
    );

    assign m_axis_video.tvalid = s2_valid;
    assign {m_axis_video.tuser, m_axis_video.tlast, m_axis_video.tdata} = s2_out;

    // Each output start-of-frame closes the previous frame, except the very first one
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_count <= '0;
            seen_sof    <= 1'b0;
        end else if (out_hs && m_axis_video.tuser) begin
            if (seen_sof) begin
                frame_count <= frame_count + FCNT_W'(1);
            end
            seen_sof <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_filter.sv
// Directed bench for pixel_filter: modes, mode latching, backpressure, frame counting and reset.
module tb_pixel_filter;

    localparam int unsigned CH_W   = 8;
    localparam int unsigned FCNT_W = 3;

    logic              aclk    = 1'b0;
    logic              aresetn = 1'b1;
    logic [1:0]        mode;
    logic [CH_W-1:0]   threshold;
    logic [FCNT_W-1:0] frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] rx_data[$];
    logic        rx_user[$];
    logic        rx_last[$];

    pixel_filter_if #(.CH_W(CH_W)) s_if ();
    pixel_filter_if #(.CH_W(CH_W)) m_if ();

    pixel_filter #(.CH_W(CH_W), .FCNT_W(FCNT_W)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axis_video (s_if),
        .m_axis_video (m_if),
        .mode         (mode),
        .threshold    (threshold),
        .frame_count  (frame_count)
    );

    always #5 aclk = ~aclk;

    // Record beats that will hand over on the coming rising edge
    always @(negedge aclk) begin
        if (aresetn && m_if.tvalid && m_if.tready) begin
            rx_data.push_back(m_if.tdata);
            rx_user.push_back(m_if.tuser);
            rx_last.push_back(m_if.tlast);
        end
    end

    task automatic clear_rx();
        rx_data.delete();
        rx_user.delete();
        rx_last.delete();
    endtask

    task automatic drive_beat(input logic [23:0] d, input logic u, input logic l);
        bit done;
        done = 1'b0;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge aclk);
            done = s_if.tready;
            @(posedge aclk);
            #1;
        end
        s_if.tvalid = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL input_accept: beat %h not accepted, tready stayed %b", d, s_if.tready);
        end
    endtask

    task automatic apply_reset();
        s_if.tvalid = 1'b0;
        aresetn     = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        clear_rx();
    endtask

    task automatic test_reset();
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        mode        = 2'd0;
        threshold   = '0;
        #2 aresetn = 1'b0;
        #1;
        n_tests++;
        if ({m_if.tvalid, m_if.tuser, m_if.tlast} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000", {m_if.tvalid, m_if.tuser, m_if.tlast});
        end
        n_tests++;
        if (m_if.tdata !== 24'h000000) begin
            n_fail++;
            $display("FAIL reset_tdata: got %h expected 000000", m_if.tdata);
        end
        n_tests++;
        if (frame_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_fcnt: got %0d expected 0", frame_count);
        end
        n_tests++;
        if (s_if.tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tready: got %b expected 0", s_if.tready);
        end
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk);
        #1;
        n_tests++;
        if (s_if.tready !== 1'b1 || m_if.tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got tready %b tvalid %b expected 1 0", s_if.tready, m_if.tvalid);
        end
    endtask

    task automatic test_grey();
        m_if.tready = 1'b1;
        mode        = 2'd1;
        drive_beat(24'hFF0000, 1'b1, 1'b1);
        n_tests++;
        if (m_if.tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL grey_latency_early: tvalid %b expected 0", m_if.tvalid);
        end
        @(posedge aclk);
        #1;
        n_tests++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 24'h4C4C4C) begin
            n_fail++;
            $display("FAIL grey_data: got valid %b data %h expected 1 4c4c4c", m_if.tvalid, m_if.tdata);
        end
        n_tests++;
        if ({m_if.tuser, m_if.tlast} !== 2'b11) begin
            n_fail++;
            $display("FAIL grey_sideband: got %b expected 11", {m_if.tuser, m_if.tlast});
        end
        @(posedge aclk);
        #1;
        n_tests++;
        if (m_if.tvalid !== 1'b0 || frame_count !== 3'd0) begin
            n_fail++;
            $display("FAIL grey_drain: got valid %b fcnt %0d expected 0 0", m_if.tvalid, frame_count);
        end
    endtask

    task automatic test_invert();
        mode = 2'd2;
        drive_beat(24'h102030, 1'b1, 1'b0);
        @(posedge aclk);
        #1;
        n_tests++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 24'hEFDFCF) begin
            n_fail++;
            $display("FAIL invert_data: got valid %b data %h expected 1 efdfcf", m_if.tvalid, m_if.tdata);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_thresh();
        mode      = 2'd3;
        threshold = 8'd128;
        drive_beat(24'hFFFFFF, 1'b1, 1'b0);
        threshold = 8'd0;
        drive_beat(24'h404040, 1'b0, 1'b0);
        n_tests++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 24'hFFFFFF) begin
            n_fail++;
            $display("FAIL thresh_white: got %h expected ffffff", m_if.tdata);
        end
        drive_beat(24'h808080, 1'b0, 1'b0);
        n_tests++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 24'h000000) begin
            n_fail++;
            $display("FAIL thresh_black: got %h expected 000000", m_if.tdata);
        end
        drive_beat(24'h7F7F7F, 1'b0, 1'b1);
        n_tests++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 24'hFFFFFF) begin
            n_fail++;
            $display("FAIL thresh_equal: got %h expected ffffff", m_if.tdata);
        end
        @(posedge aclk);
        #1;
        n_tests++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 24'h000000 || m_if.tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL thresh_below: got %h last %b expected 000000 1", m_if.tdata, m_if.tlast);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_mode_switch();
        logic [23:0] exp_d [5];
        logic        exp_u [5];
        exp_d = '{24'h242424, 24'h4C4C4C, 24'hFFFFFF, 24'hEFDFCF, 24'hFFFFFF};
        exp_u = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        clear_rx();
        mode = 2'd1;
        drive_beat(24'h102030, 1'b1, 1'b0);
        mode = 2'd2;
        drive_beat(24'hFF0000, 1'b0, 1'b0);
        drive_beat(24'hFFFFFF, 1'b0, 1'b1);
        drive_beat(24'h102030, 1'b1, 1'b0);
        drive_beat(24'h000000, 1'b0, 1'b1);
        repeat (5) @(posedge aclk);
        #1;
        n_tests++;
        if (rx_data.size() != 5) begin
            n_fail++;
            $display("FAIL switch_count: got %0d beats expected 5", rx_data.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (rx_data[i] !== exp_d[i] || rx_user[i] !== exp_u[i]) begin
                    n_fail++;
                    $display("FAIL switch_beat%0d: got %h user %b expected %h user %b",
                             i, rx_data[i], rx_user[i], exp_d[i], exp_u[i]);
                end
            end
        end
        n_tests++;
        if (frame_count !== 3'd4) begin
            n_fail++;
            $display("FAIL switch_fcnt: got %0d expected 4", frame_count);
        end
    endtask

    task automatic test_backpressure();
        logic [25:0] exp_q[$];
        logic [25:0] prev_word;
        logic [25:0] got;
        bit          prev_stall;
        apply_reset();
        mode        = 2'd0;
        m_if.tready = 1'b0;
        prev_stall  = 1'b0;
        prev_word   = '0;
        fork
            begin
                for (int f = 0; f < 3; f++)
                    for (int y = 0; y < 3; y++)
                        for (int x = 0; x < 4; x++) begin
                            logic [23:0] d;
                            logic        u, l;
                            d = {8'(f + 1), 8'(y * 16), 8'(x + 8'hA0)};
                            u = (x == 0) && (y == 0);
                            l = (x == 3);
                            exp_q.push_back({u, l, d});
                            drive_beat(d, u, l);
                        end
            end
            begin
                for (int c = 0; c < 1000 && rx_data.size() < 36; c++) begin
                    @(negedge aclk);
                    if (prev_stall) begin
                        n_tests++;
                        if (m_if.tvalid !== 1'b1 ||
                            {m_if.tuser, m_if.tlast, m_if.tdata} !== prev_word) begin
                            n_fail++;
                            $display("FAIL stall_stable: got v%b %h expected v1 %h", m_if.tvalid,
                                     {m_if.tuser, m_if.tlast, m_if.tdata}, prev_word);
                        end
                    end
                    prev_stall = m_if.tvalid && !m_if.tready;
                    prev_word  = {m_if.tuser, m_if.tlast, m_if.tdata};
                    @(posedge aclk);
                    #1;
                    m_if.tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_if.tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        n_tests++;
        if (rx_data.size() != 36) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats expected 36", rx_data.size());
        end else begin
            for (int i = 0; i < 36; i++) begin
                got = {rx_user[i], rx_last[i], rx_data[i]};
                n_tests++;
                if (got !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: got %h expected %h", i, got, exp_q[i]);
                end
            end
        end
        n_tests++;
        if (frame_count !== 3'd2) begin
            n_fail++;
            $display("FAIL bp_fcnt: got %0d expected 2", frame_count);
        end
    endtask

    task automatic test_wrap();
        m_if.tready = 1'b1;
        for (int i = 0; i < 5; i++) drive_beat(24'h010203, 1'b1, 1'b1);
        repeat (3) @(posedge aclk);
        #1;
        n_tests++;
        if (frame_count !== 3'd7) begin
            n_fail++;
            $display("FAIL fcnt_max: got %0d expected 7", frame_count);
        end
        drive_beat(24'h040506, 1'b1, 1'b1);
        repeat (3) @(posedge aclk);
        #1;
        n_tests++;
        if (frame_count !== 3'd0) begin
            n_fail++;
            $display("FAIL fcnt_wrap: got %0d expected 0", frame_count);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mode        = 2'd0;
        m_if.tready = 1'b1;
        drive_beat(24'h111111, 1'b1, 1'b1);
        drive_beat(24'h222222, 1'b1, 1'b0);
        repeat (3) @(posedge aclk);
        #1;
        n_tests++;
        if (frame_count !== 3'd1) begin
            n_fail++;
            $display("FAIL midrst_pre_fcnt: got %0d expected 1", frame_count);
        end
        m_if.tready = 1'b0;
        drive_beat(24'h333333, 1'b0, 1'b0);
        drive_beat(24'h444444, 1'b0, 1'b1);
        n_tests++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 24'h333333) begin
            n_fail++;
            $display("FAIL midrst_full: got v%b %h expected v1 333333", m_if.tvalid, m_if.tdata);
        end
        aresetn = 1'b0;
        #1;
        n_tests++;
        if ({m_if.tvalid, m_if.tuser, m_if.tlast} !== 3'b000 || m_if.tdata !== 24'h000000) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b %h expected 000 000000",
                     {m_if.tvalid, m_if.tuser, m_if.tlast}, m_if.tdata);
        end
        n_tests++;
        if (frame_count !== 3'd0 || s_if.tready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_fcnt_ready: got %0d %b expected 0 0", frame_count, s_if.tready);
        end
        @(posedge aclk);
        #1 aresetn = 1'b1;
        m_if.tready = 1'b1;
        clear_rx();
        repeat (5) @(posedge aclk);
        #1;
        n_tests++;
        if (rx_data.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_stale: got %0d beats expected 0", rx_data.size());
        end
        drive_beat(24'hABCDEF, 1'b1, 1'b0);
        repeat (3) @(posedge aclk);
        #1;
        n_tests++;
        if (rx_data.size() != 1 || rx_data[0] !== 24'hABCDEF || rx_user[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_fresh: got %0d beats first %h expected 1 abcdef",
                     rx_data.size(), (rx_data.size() > 0) ? rx_data[0] : 24'h0);
        end
        n_tests++;
        if (frame_count !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_fcnt: got %0d expected 0", frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_grey();
        test_invert();
        test_thresh();
        test_mode_switch();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
